// File: rtl/vector_pair_streamer_pkg.sv
// Shared definitions for the VectorAdd operand streamers: FSM state encoding and index sizing.
// Combinational helpers only; no latency, no flow control.
package vector_pair_streamer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Index width for a vector of len elements; never narrower than one bit.
  function automatic int idx_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/vector_element_mux.sv
// Combinational element selector: returns element idx of a packed vector (element 0 in the LSBs).
// Zero latency, no flow control; out-of-range indices return element 0.
module vector_element_mux
  import vector_pair_streamer_pkg::*;
#(
  parameter int IN_WIDTH = 10,
  parameter int LENGTH   = 4,
  localparam int IDX_WIDTH = idx_width(LENGTH)
) (
  input  logic [LENGTH*IN_WIDTH-1:0] vec,
  input  logic [IDX_WIDTH-1:0]       idx,
  output logic signed [IN_WIDTH-1:0] elem
);

  always_comb begin
    elem = vec[IN_WIDTH-1:0];
    for (int i = 1; i < LENGTH; i++) begin
      if (idx == IDX_WIDTH'(i)) begin
        elem = vec[i*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

endmodule

// File: rtl/vector_pair_streamer.sv
// Captures two vectors on start and issues one registered (A[i],B[i]) pair per enabled cycle.
// Pair i visible 1+i enabled cycles after the accepting edge; enable=0 freezes everything.
module vector_pair_streamer
  import vector_pair_streamer_pkg::*;
#(
  parameter int IN_WIDTH = 10,
  parameter int LENGTH   = 4,
  localparam int IDX_WIDTH = idx_width(LENGTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       start,
  input  logic [LENGTH*IN_WIDTH-1:0] vecA,
  input  logic [LENGTH*IN_WIDTH-1:0] vecB,
  output logic                       idle,
  output logic                       outReady,
  output logic signed [IN_WIDTH-1:0] O0,
  output logic signed [IN_WIDTH-1:0] O1,
  output logic [IDX_WIDTH-1:0]       outIndex,
  output logic                       lastOut
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LENGTH - 1);

  state_t                      state_q, state_d;
  logic [IDX_WIDTH-1:0]        cnt_q, cnt_d;
  logic [LENGTH*IN_WIDTH-1:0]  reg_a_q, reg_a_d;
  logic [LENGTH*IN_WIDTH-1:0]  reg_b_q, reg_b_d;
  logic signed [IN_WIDTH-1:0]  o0_q, o0_d;
  logic signed [IN_WIDTH-1:0]  o1_q, o1_d;
  logic [IDX_WIDTH-1:0]        out_index_q, out_index_d;
  logic                        out_ready_q, out_ready_d;
  logic                        last_out_q, last_out_d;
  logic signed [IN_WIDTH-1:0]  elem_a, elem_b;

  vector_element_mux #(.IN_WIDTH(IN_WIDTH), .LENGTH(LENGTH)) u_mux_a (
    .vec  (reg_a_q),
    .idx  (cnt_q),
    .elem (elem_a)
  );

  vector_element_mux #(.IN_WIDTH(IN_WIDTH), .LENGTH(LENGTH)) u_mux_b (
    .vec  (reg_b_q),
    .idx  (cnt_q),
    .elem (elem_b)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reg_a_d     = reg_a_q;
    reg_b_d     = reg_b_q;
    o0_d        = o0_q;
    o1_d        = o1_q;
    out_index_d = out_index_q;
    out_ready_d = out_ready_q;
    last_out_d  = last_out_q;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          out_ready_d = 1'b0;
          last_out_d  = 1'b0;
          if (start) begin
            reg_a_d = vecA;
            reg_b_d = vecB;
            cnt_d   = '0;
            state_d = ST_STREAM;
          end
        end
        ST_STREAM: begin
          o0_d        = elem_a;
          o1_d        = elem_b;
          out_index_d = cnt_q;
          out_ready_d = 1'b1;
          last_out_d  = (cnt_q == LAST_IDX);
          if (cnt_q != LAST_IDX) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            // A start on the final pair reloads without an idle bubble.
            if (start) begin
              reg_a_d = vecA;
              reg_b_d = vecB;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_index_q <= '0;
      out_ready_q <= 1'b0;
      last_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_index_q <= out_index_d;
      out_ready_q <= out_ready_d;
      last_out_q  <= last_out_d;
    end
  end

  // Data registers are only meaningful while outReady is high, so they carry no reset.
  always_ff @(posedge clk) begin
    reg_a_q <= reg_a_d;
    reg_b_q <= reg_b_d;
    o0_q    <= o0_d;
    o1_q    <= o1_d;
  end

  assign idle     = (state_q == ST_IDLE);
  assign outReady = out_ready_q;
  assign lastOut  = last_out_q;
  assign outIndex = out_index_q;
  assign O0       = o0_q;
  assign O1       = o1_q;

endmodule

// File: tb/tb_vector_pair_streamer.sv
// Randomized and directed bench for vector_pair_streamer against a queue-based pair model.
module tb_vector_pair_streamer;

  localparam int W  = 10;
  localparam int L  = 4;
  localparam int IW = 2;
  localparam int VW = W * L;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic [VW-1:0] vecA = '0;
  logic [VW-1:0] vecB = '0;
  logic          idle, outReady, lastOut;
  logic signed [W-1:0] O0, O1;
  logic [IW-1:0] outIndex;

  vector_pair_streamer #(.IN_WIDTH(W), .LENGTH(L)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .vecA(vecA), .vecB(vecB), .idle(idle), .outReady(outReady),
    .O0(O0), .O1(O1), .outIndex(outIndex), .lastOut(lastOut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a queue of pairs still owed to the consumer.
  typedef struct {
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    int                  idx;
    bit                  last;
  } pair_t;

  pair_t               pend[$];
  bit                  exp_rdy = 0, exp_last = 0, exp_idle = 1;
  logic signed [W-1:0] exp_a = '0, exp_b = '0;
  logic [IW-1:0]       exp_idx = '0;

  function automatic void push_vec(input logic [VW-1:0] a, input logic [VW-1:0] b);
    for (int i = 0; i < L; i++) begin
      pair_t p;
      p.a = a[i*W +: W];
      p.b = b[i*W +: W];
      p.idx = i;
      p.last = (i == L - 1);
      pend.push_back(p);
    end
  endfunction

  function automatic void model_edge(input bit s, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                     input bit en, input bit rst);
    if (rst) begin
      pend.delete();
      exp_rdy = 0; exp_last = 0; exp_idx = '0;
    end else if (en) begin
      if (pend.size() > 0) begin
        pair_t p;
        p = pend.pop_front();
        exp_rdy = 1; exp_last = p.last; exp_a = p.a; exp_b = p.b; exp_idx = IW'(p.idx);
        if (p.last && s) push_vec(a, b);
      end else begin
        exp_rdy = 0; exp_last = 0;
        if (s) push_vec(a, b);
      end
    end
    exp_idle = (pend.size() == 0);
  endfunction

  task automatic tick(input bit s, input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input bit en, input bit rst);
    start = s; vecA = a; vecB = b; enable = en; reset = rst;
    @(posedge clk);
    model_edge(s, a, b, en, rst);
    #1;
  endtask

  function automatic logic [VW-1:0] pack4(input int e3, input int e2, input int e1, input int e0);
    return {W'(e3), W'(e2), W'(e1), W'(e0)};
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[VW-1:0];
  endfunction

  task automatic report(input string name);
    $display("FAIL %s t=%0t rdy=%b exp %b last=%b exp %b idle=%b exp %b idx=%0d exp %0d O0=%0d exp %0d O1=%0d exp %0d",
             name, $time, outReady, exp_rdy, lastOut, exp_last, idle, exp_idle,
             outIndex, exp_idx, O0, exp_a, O1, exp_b);
  endtask

  task automatic test_reset();
    tick(0, '0, '0, 1, 1);
    tick(0, '0, '0, 0, 1);
    checks++;
    if (outReady !== 1'b0 || lastOut !== 1'b0 || outIndex !== 2'd0 || idle !== 1'b1) begin
      errors++; report("reset");
    end
    tick(0, '0, '0, 1, 0);
  endtask

  task automatic test_basic();
    logic [VW-1:0] a, b;
    a = pack4(4, 3, 2, 1);
    b = pack4(-1, -2, -3, -4);
    tick(1, a, b, 1, 0);
    for (int i = 0; i < L; i++) begin
      tick(0, rand_vec(), rand_vec(), 1, 0);
      checks++;
      if (outReady !== 1'b1 || O0 !== W'(i + 1) || O1 !== W'(i - 4) ||
          outIndex !== IW'(i) || lastOut !== (i == L - 1) || idle !== (i == L - 1)) begin
        errors++; report("basic_pair");
      end
    end
    tick(0, '0, '0, 1, 0);
    checks++;
    if (outReady !== 1'b0 || lastOut !== 1'b0 || idle !== 1'b1) begin
      errors++; report("basic_after");
    end
  endtask

  task automatic test_enable_hold();
    logic [VW-1:0] a, b;
    a = rand_vec(); b = rand_vec();
    tick(1, a, b, 1, 0);
    tick(0, a, b, 1, 0);
    tick(0, a, b, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(i == 1, rand_vec(), rand_vec(), 0, 0);
      checks++;
      if (outReady !== 1'b1 || outIndex !== 2'd1 || O0 !== a[W +: W] || O1 !== b[W +: W] ||
          lastOut !== 1'b0) begin
        errors++; report("hold");
      end
    end
    for (int i = 2; i < L + 1; i++) begin
      tick(0, '0, '0, 1, 0);
      checks++;
      if (outReady !== exp_rdy || lastOut !== exp_last || idle !== exp_idle ||
          outIndex !== exp_idx || (exp_rdy && (O0 !== exp_a || O1 !== exp_b))) begin
        errors++; report("resume");
      end
    end
  endtask

  task automatic test_back_to_back();
    int strobes = 0;
    tick(1, rand_vec(), rand_vec(), 1, 0);
    for (int i = 0; i < 2 * L; i++) begin
      tick(i < L, rand_vec(), rand_vec(), 1, 0);
      if (outReady === 1'b1) strobes++;
      checks++;
      if (outReady !== exp_rdy || lastOut !== exp_last || idle !== exp_idle ||
          outIndex !== exp_idx || (exp_rdy && (O0 !== exp_a || O1 !== exp_b))) begin
        errors++; report("b2b");
      end
    end
    checks++;
    if (strobes != 2 * L) begin
      errors++;
      $display("FAIL b2b_strobes got %0d want %0d", strobes, 2 * L);
    end
    tick(0, '0, '0, 1, 0);
    checks++;
    if (idle !== 1'b1 || outReady !== 1'b0) begin errors++; report("b2b_end"); end
  endtask

  task automatic test_start_ignored();
    int strobes = 0;
    logic [VW-1:0] a, b;
    a = rand_vec(); b = rand_vec();
    tick(1, a, b, 1, 0);
    for (int i = 0; i < L + 3; i++) begin
      tick(i == 2, rand_vec(), rand_vec(), 1, 0);
      if (outReady === 1'b1) strobes++;
      checks++;
      if (outReady !== exp_rdy || lastOut !== exp_last || idle !== exp_idle ||
          outIndex !== exp_idx || (exp_rdy && (O0 !== exp_a || O1 !== exp_b))) begin
        errors++; report("ignore");
      end
    end
    checks++;
    if (strobes != L) begin
      errors++;
      $display("FAIL ignore_strobes got %0d want %0d", strobes, L);
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] a, b;
    for (int en = 1; en >= 0; en--) begin
      tick(1, rand_vec(), rand_vec(), 1, 0);
      for (int i = 0; i < 3; i++) tick(0, '0, '0, 1, 0);
      checks++;
      if (outIndex !== 2'd2 || outReady !== 1'b1) begin errors++; report("mid_setup"); end
      tick(0, '0, '0, en[0], 1);
      tick(0, '0, '0, 1, 0);
      checks++;
      if (outReady !== 1'b0 || idle !== 1'b1 || lastOut !== 1'b0) begin
        errors++; report("mid_reset");
      end
      a = rand_vec(); b = rand_vec();
      tick(1, a, b, 1, 0);
      tick(0, '0, '0, 1, 0);
      checks++;
      if (outReady !== 1'b1 || outIndex !== 2'd0 || O0 !== a[W-1:0] || O1 !== b[W-1:0]) begin
        errors++; report("mid_restart");
      end
      for (int i = 0; i < L; i++) tick(0, '0, '0, 1, 0);
    end
  endtask

  task automatic test_extremes();
    logic [VW-1:0] a, b;
    logic signed [W:0] sum;
    a = pack4(511, -512, 511, -512);
    b = pack4(-512, 511, -512, 511);
    tick(1, a, b, 1, 0);
    for (int i = 0; i < L; i++) begin
      tick(0, '0, '0, 1, 0);
      sum = W'(O0) + W'(O1);
      sum = (W + 1)'(O0) + (W + 1)'(O1);
      checks++;
      if (outReady !== 1'b1 || O0 !== a[i*W +: W] || O1 !== b[i*W +: W] || sum !== -11'sd1) begin
        errors++; report("extreme");
        $display("FAIL extreme_sum got %0d want -1", sum);
      end
    end
    tick(0, '0, '0, 1, 0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick($urandom_range(0, 2) == 0, rand_vec(), rand_vec(),
           $urandom_range(0, 5) != 0, $urandom_range(0, 60) == 0);
      checks++;
      if (outReady !== exp_rdy || lastOut !== exp_last || idle !== exp_idle ||
          outIndex !== exp_idx || (exp_rdy && (O0 !== exp_a || O1 !== exp_b))) begin
        errors++; report("random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enable_hold();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_extremes();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
